// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX frame serializer: FSM states, byte width
// and the width helpers used for sizing counters and index ports.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

  // Same as clog2 but never narrower than one bit, so index and counter
  // vectors stay legal when the parameter is 1 (or 0 for the gap).
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/frame_byte_select.sv
// Byte-lane multiplexer: picks the 8-bit slice of a captured frame that
// corresponds to the transmit position idx, honouring the byte order.
module frame_byte_select
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int LSB_FIRST = 1,
  parameter int IDX_W     = 1
) (
  input  logic [BYTE_W*NUM_BYTES-1:0] frame,
  input  logic [IDX_W-1:0]            idx,
  output logic [BYTE_W-1:0]           byte_out
);

  // lane[i] is the byte transmitted at position i, already reordered.
  logic [BYTE_W-1:0] lane [NUM_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      if (LSB_FIRST != 0) begin : g_lsb
        assign lane[gi] = frame[BYTE_W*gi +: BYTE_W];
      end else begin : g_msb
        assign lane[gi] = frame[BYTE_W*(NUM_BYTES-1-gi) +: BYTE_W];
      end
    end
  endgenerate

  // Position decode; an out-of-range index yields zero rather than X.
  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (int'(idx) == i) begin
        byte_out = lane[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// Captures an N-byte frame on a start request and hands it to the UART TX
// core one byte at a time over a 4-phase valid/done handshake, with optional
// idle gap between bytes, busy status and a frame-complete pulse.
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int NUM_BYTES  = 2,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [BYTE_W*NUM_BYTES-1:0]          frame_in,
  input  logic                                 tx_done,
  output logic [BYTE_W-1:0]                    tx_data,
  output logic                                 tx_valid,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [clog2_min1(NUM_BYTES)-1:0]     byte_idx
);

  localparam int FRAME_W = BYTE_W * NUM_BYTES;
  localparam int IDX_W   = clog2_min1(NUM_BYTES);
  localparam int GAP_W   = clog2_min1(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  state_t               state_reg,      state_next;
  logic [FRAME_W-1:0]   buffer_reg,     buffer_next;
  logic [IDX_W-1:0]     byte_idx_reg,   byte_idx_next;
  logic [GAP_W-1:0]     gap_cnt_reg,    gap_cnt_next;
  logic [BYTE_W-1:0]    tx_data_reg,    tx_data_next;
  logic                 tx_valid_reg,   tx_valid_next;
  logic                 busy_reg,       busy_next;
  logic                 frame_done_reg, frame_done_next;

  // Byte-select inputs: the frame and position of the byte about to be sent.
  logic [FRAME_W-1:0]   sel_frame;
  logic [IDX_W-1:0]     sel_idx;
  logic [BYTE_W-1:0]    sel_byte;

  // Point the mux at the byte that the next SEND entry will present, so
  // tx_data can be loaded in the same edge that raises tx_valid.
  always_comb begin
    sel_frame = buffer_reg;
    sel_idx   = byte_idx_reg;
    case (state_reg)
      IDLE: begin
        // The buffer is written on this very edge, so select from frame_in.
        sel_frame = frame_in;
        sel_idx   = '0;
      end
      RELEASE: begin
        // Zero-gap path goes straight to the following byte.
        sel_idx = byte_idx_reg + IDX_W'(1);
      end
      default: begin
      end
    endcase
  end

  frame_byte_select #(
    .NUM_BYTES (NUM_BYTES),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_byte_select (
    .frame    (sel_frame),
    .idx      (sel_idx),
    .byte_out (sel_byte)
  );

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_next      = state_reg;
    buffer_next     = buffer_reg;
    byte_idx_next   = byte_idx_reg;
    gap_cnt_next    = gap_cnt_reg;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = tx_valid_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          buffer_next   = frame_in;
          byte_idx_next = '0;
          tx_data_next  = sel_byte;
          tx_valid_next = 1'b1;
          busy_next     = 1'b1;
          state_next    = SEND;
        end
      end

      SEND: begin
        // Request held until the core acknowledges; no timeout.
        if (tx_done) begin
          tx_valid_next = 1'b0;
          state_next    = RELEASE;
        end
      end

      RELEASE: begin
        // Wait for the acknowledge to drop before moving on.
        if (!tx_done) begin
          if (byte_idx_reg == LAST_IDX) begin
            frame_done_next = 1'b1;
            busy_next       = 1'b0;
            state_next      = IDLE;
          end else begin
            byte_idx_next = byte_idx_reg + IDX_W'(1);
            if (GAP_CYCLES == 0) begin
              tx_data_next  = sel_byte;
              tx_valid_next = 1'b1;
              state_next    = SEND;
            end else begin
              gap_cnt_next = GAP_LOAD;
              state_next   = GAP;
            end
          end
        end
      end

      GAP: begin
        // Counter runs GAP_CYCLES..1, one cycle each, then requests the byte.
        if (gap_cnt_reg <= GAP_W'(1)) begin
          gap_cnt_next  = '0;
          tx_data_next  = sel_byte;
          tx_valid_next = 1'b1;
          state_next    = SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers; reset clears them without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer_reg     <= '0;
      byte_idx_reg   <= '0;
      gap_cnt_reg    <= '0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      buffer_reg     <= buffer_next;
      byte_idx_reg   <= byte_idx_next;
      gap_cnt_reg    <= gap_cnt_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign byte_idx   = byte_idx_reg;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer using four instances:
// a: 2 bytes LSB first, b: 4 bytes MSB first, c: 2 bytes with 3-cycle gap,
// d: single byte. Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en    [4];
  logic        done  [4];
  logic [7:0]  data  [4];
  logic        valid [4];
  logic        busy  [4];
  logic        fdone [4];
  logic [1:0]  idx   [4];

  logic [15:0] frame_a;
  logic [31:0] frame_b;
  logic [15:0] frame_c;
  logic [7:0]  frame_d;
  logic [0:0]  idx_a;
  logic [1:0]  idx_b;
  logic [0:0]  idx_c;
  logic [0:0]  idx_d;

  assign idx[0] = {1'b0, idx_a};
  assign idx[1] = idx_b;
  assign idx[2] = {1'b0, idx_c};
  assign idx[3] = {1'b0, idx_d};

  int vectors     = 0;
  int miscompares = 0;
  int fd_cnt [4]  = '{0, 0, 0, 0};

  uart_tx_frame_serializer #(.NUM_BYTES(2), .LSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(rst), .enable(en[0]), .frame_in(frame_a), .tx_done(done[0]),
    .tx_data(data[0]), .tx_valid(valid[0]), .busy(busy[0]), .frame_done(fdone[0]), .byte_idx(idx_a));

  uart_tx_frame_serializer #(.NUM_BYTES(4), .LSB_FIRST(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst), .enable(en[1]), .frame_in(frame_b), .tx_done(done[1]),
    .tx_data(data[1]), .tx_valid(valid[1]), .busy(busy[1]), .frame_done(fdone[1]), .byte_idx(idx_b));

  uart_tx_frame_serializer #(.NUM_BYTES(2), .LSB_FIRST(1), .GAP_CYCLES(3)) dut_c (
    .clk(clk), .reset(rst), .enable(en[2]), .frame_in(frame_c), .tx_done(done[2]),
    .tx_data(data[2]), .tx_valid(valid[2]), .busy(busy[2]), .frame_done(fdone[2]), .byte_idx(idx_c));

  uart_tx_frame_serializer #(.NUM_BYTES(1), .LSB_FIRST(1), .GAP_CYCLES(0)) dut_d (
    .clk(clk), .reset(rst), .enable(en[3]), .frame_in(frame_d), .tx_done(done[3]),
    .tx_data(data[3]), .tx_valid(valid[3]), .busy(busy[3]), .frame_done(fdone[3]), .byte_idx(idx_d));

  // Count frame_done pulses per instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fdone[k] === 1'b1) fd_cnt[k]++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Full acknowledge: raise done for one cycle, then drop it for one cycle.
  task automatic ack(input int k);
    done[k] = 1'b1;
    tick();
    done[k] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({valid[k], busy[k], fdone[k], data[k], idx[k]} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got v=%b b=%b fd=%b d=%h i=%0d want all 0",
                 k, valid[k], busy[k], fdone[k], data[k], idx[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lsb_two_byte();
    int snap;
    snap = fd_cnt[0];
    frame_a = 16'hA55A; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    vectors++;
    if ({valid[0], busy[0], data[0], idx[0]} !== {1'b1, 1'b1, 8'h5A, 2'd0}) begin
      miscompares++;
      $display("FAIL lsb_byte0: got v=%b b=%b d=%h i=%0d want v=1 b=1 d=5a i=0", valid[0], busy[0], data[0], idx[0]);
    end
    repeat (5) tick();
    vectors++;
    if ({valid[0], data[0]} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL lsb_stall_hold: got v=%b d=%h want v=1 d=5a", valid[0], data[0]);
    end
    done[0] = 1'b1;
    tick();
    vectors++;
    if ({valid[0], busy[0]} !== 2'b01) begin
      miscompares++;
      $display("FAIL lsb_ack_drop: got v=%b b=%b want v=0 b=1", valid[0], busy[0]);
    end
    done[0] = 1'b0;
    tick();
    $display("txn dut0 byte %0d data %h", idx[0], data[0]);
    vectors++;
    if ({valid[0], data[0], idx[0], fdone[0]} !== {1'b1, 8'hA5, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL lsb_byte1: got v=%b d=%h i=%0d fd=%b want v=1 d=a5 i=1 fd=0", valid[0], data[0], idx[0], fdone[0]);
    end
    repeat (5) tick();
    ack(0);
    vectors++;
    if ({fdone[0], busy[0], valid[0], data[0]} !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL lsb_frame_end: got fd=%b b=%b v=%b d=%h want fd=1 b=0 v=0 d=a5", fdone[0], busy[0], valid[0], data[0]);
    end
    tick();
    vectors++;
    if (fdone[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_fd_one_cycle: got %b want 0", fdone[0]);
    end
    tick();
    vectors++;
    if (fd_cnt[0] - snap !== 1) begin
      miscompares++;
      $display("FAIL lsb_fd_count: got %0d want 1", fd_cnt[0] - snap);
    end
  endtask

  task automatic test_msb_four_byte();
    logic [7:0] exp_b [4];
    int snap;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    snap = fd_cnt[1];
    frame_b = 32'h11223344; en[1] = 1'b1;
    tick();
    en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      $display("txn dut1 byte %0d data %h", idx[1], data[1]);
      vectors++;
      if ({valid[1], data[1], idx[1]} !== {1'b1, exp_b[i], 2'(i)}) begin
        miscompares++;
        $display("FAIL msb_byte%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", i, valid[1], data[1], idx[1], exp_b[i], i);
      end
      repeat (2) tick();
      done[1] = 1'b1;
      tick();
      vectors++;
      if ({valid[1], fdone[1]} !== 2'b00) begin
        miscompares++;
        $display("FAIL msb_release%0d: got v=%b fd=%b want v=0 fd=0", i, valid[1], fdone[1]);
      end
      done[1] = 1'b0;
      tick();
      if (i == 3) begin
        vectors++;
        if ({fdone[1], busy[1]} !== 2'b10) begin
          miscompares++;
          $display("FAIL msb_frame_end: got fd=%b b=%b want fd=1 b=0", fdone[1], busy[1]);
        end
      end
    end
    repeat (2) tick();
    vectors++;
    if (fd_cnt[1] - snap !== 1) begin
      miscompares++;
      $display("FAIL msb_fd_count: got %0d want 1", fd_cnt[1] - snap);
    end
  endtask

  task automatic test_gap();
    int n;
    frame_c = 16'h3CC3; en[2] = 1'b1;
    tick();
    en[2] = 1'b0;
    vectors++;
    if ({valid[2], data[2]} !== {1'b1, 8'hC3}) begin
      miscompares++;
      $display("FAIL gap_byte0: got v=%b d=%h want v=1 d=c3", valid[2], data[2]);
    end
    done[2] = 1'b1;
    tick();
    done[2] = 1'b0;
    n = 0;
    // A stray done pulse inside GAP must be ignored.
    while (valid[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
      done[2] = (n == 1);
    end
    done[2] = 1'b0;
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL gap_low_cycles: got %0d want 4", n);
    end
    $display("txn dut2 byte %0d data %h", idx[2], data[2]);
    vectors++;
    if ({valid[2], data[2], idx[2]} !== {1'b1, 8'h3C, 2'd1}) begin
      miscompares++;
      $display("FAIL gap_byte1: got v=%b d=%h i=%0d want v=1 d=3c i=1", valid[2], data[2], idx[2]);
    end
    ack(2);
    vectors++;
    if ({fdone[2], busy[2]} !== 2'b10) begin
      miscompares++;
      $display("FAIL gap_frame_end: got fd=%b b=%b want fd=1 b=0", fdone[2], busy[2]);
    end
    tick();
  endtask

  task automatic test_enable_ignored();
    int snap;
    snap = fd_cnt[0];
    frame_a = 16'hA55A; en[0] = 1'b1;
    tick();
    frame_a = 16'hFFFF;
    repeat (2) tick();
    en[0] = 1'b0;
    vectors++;
    if ({valid[0], data[0]} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL ign_byte0: got v=%b d=%h want v=1 d=5a", valid[0], data[0]);
    end
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    vectors++;
    if ({valid[0], data[0]} !== {1'b1, 8'hA5}) begin
      miscompares++;
      $display("FAIL ign_byte1: got v=%b d=%h want v=1 d=a5", valid[0], data[0]);
    end
    ack(0);
    vectors++;
    if (fdone[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_frame_end: got fd=%b want 1", fdone[0]);
    end
    repeat (3) tick();
    vectors++;
    if ({valid[0], busy[0], fd_cnt[0] - snap} !== {1'b0, 1'b0, 32'sd1}) begin
      miscompares++;
      $display("FAIL ign_no_second_frame: got v=%b b=%b frames=%0d want v=0 b=0 frames=1", valid[0], busy[0], fd_cnt[0] - snap);
    end
  endtask

  task automatic test_back_to_back();
    frame_a = 16'h1234; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    ack(0);
    vectors++;
    if ({valid[0], data[0]} !== {1'b1, 8'h12}) begin
      miscompares++;
      $display("FAIL b2b_first_byte1: got v=%b d=%h want v=1 d=12", valid[0], data[0]);
    end
    ack(0);
    vectors++;
    if (fdone[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_end: got fd=%b want 1", fdone[0]);
    end
    frame_a = 16'hBEEF; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    $display("txn dut0 byte %0d data %h", idx[0], data[0]);
    vectors++;
    if ({valid[0], busy[0], data[0], idx[0]} !== {1'b1, 1'b1, 8'hEF, 2'd0}) begin
      miscompares++;
      $display("FAIL b2b_second_start: got v=%b b=%b d=%h i=%0d want v=1 b=1 d=ef i=0", valid[0], busy[0], data[0], idx[0]);
    end
    ack(0);
    ack(0);
    vectors++;
    if (fdone[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_end: got fd=%b want 1", fdone[0]);
    end
    tick();
  endtask

  task automatic test_stuck_done();
    int bad;
    frame_a = 16'hA55A; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    done[0] = 1'b1;
    tick();
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if ({valid[0], busy[0], idx[0]} !== {1'b0, 1'b1, 2'd0}) bad++;
      tick();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stuck_hold_release: got %0d bad cycles want 0 (last v=%b i=%0d)", bad, valid[0], idx[0]);
    end
    done[0] = 1'b0;
    tick();
    vectors++;
    if ({valid[0], data[0], idx[0]} !== {1'b1, 8'hA5, 2'd1}) begin
      miscompares++;
      $display("FAIL stuck_next_byte: got v=%b d=%h i=%0d want v=1 d=a5 i=1", valid[0], data[0], idx[0]);
    end
    ack(0);
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int snap;
    snap = fd_cnt[1];
    frame_b = 32'hCAFE0102; en[1] = 1'b1;
    tick();
    en[1] = 1'b0;
    ack(1);
    vectors++;
    if ({valid[1], data[1], idx[1]} !== {1'b1, 8'hFE, 2'd1}) begin
      miscompares++;
      $display("FAIL rst_pre_byte1: got v=%b d=%h i=%0d want v=1 d=fe i=1", valid[1], data[1], idx[1]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({valid[1], busy[1], data[1], idx[1]} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_async_clear: got v=%b b=%b d=%h i=%0d want all 0", valid[1], busy[1], data[1], idx[1]);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({valid[1], fd_cnt[1] - snap} !== {1'b0, 32'sd0}) begin
      miscompares++;
      $display("FAIL rst_no_frame_done: got v=%b frames=%0d want v=0 frames=0", valid[1], fd_cnt[1] - snap);
    end
    frame_b = 32'h0A0B0C0D; en[1] = 1'b1;
    tick();
    en[1] = 1'b0;
    vectors++;
    if ({valid[1], data[1], idx[1]} !== {1'b1, 8'h0A, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_restart: got v=%b d=%h i=%0d want v=1 d=0a i=0", valid[1], data[1], idx[1]);
    end
    repeat (4) ack(1);
    vectors++;
    if (fdone[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_restart_end: got fd=%b want 1", fdone[1]);
    end
    tick();
  endtask

  task automatic test_single_byte();
    frame_d = 8'h7E; en[3] = 1'b1;
    tick();
    en[3] = 1'b0;
    vectors++;
    if ({valid[3], data[3], idx[3]} !== {1'b1, 8'h7E, 2'd0}) begin
      miscompares++;
      $display("FAIL single_byte: got v=%b d=%h i=%0d want v=1 d=7e i=0", valid[3], data[3], idx[3]);
    end
    ack(3);
    vectors++;
    if ({fdone[3], busy[3], idx[3]} !== {1'b1, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL single_end: got fd=%b b=%b i=%0d want fd=1 b=0 i=0", fdone[3], busy[3], idx[3]);
    end
    // done already high on SEND entry acts as the acknowledge at once.
    frame_d = 8'h81; en[3] = 1'b1; done[3] = 1'b1;
    tick();
    en[3] = 1'b0;
    vectors++;
    if ({valid[3], data[3]} !== {1'b1, 8'h81}) begin
      miscompares++;
      $display("FAIL early_ack_start: got v=%b d=%h want v=1 d=81", valid[3], data[3]);
    end
    tick();
    vectors++;
    if (valid[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL early_ack_drop: got v=%b want 0", valid[3]);
    end
    done[3] = 1'b0;
    tick();
    vectors++;
    if (fdone[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL early_ack_end: got fd=%b want 1", fdone[3]);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      en[k]   = 1'b0;
      done[k] = 1'b0;
    end
    frame_a = '0; frame_b = '0; frame_c = '0; frame_d = '0;

    test_reset();
    test_lsb_two_byte();
    test_msb_four_byte();
    test_gap();
    test_enable_ignored();
    test_back_to_back();
    test_stuck_done();
    test_reset_mid_frame();
    test_single_byte();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
